// File: rtl/reg_bank_if.sv
// Register bank access bus: one write port, two latched read ports, clear control.
// Latency: n/a (signal bundle only).
// Backpressure: none; busy tells the master that writes and reads are being swallowed.
interface reg_bank_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) ();
  logic               clr;
  logic               we;
  logic [AW-1:0]      wa;
  logic [WIDTH-1:0]   wd;
  logic [WIDTH/8-1:0] wbe;
  logic               re;
  logic [AW-1:0]      ra1;
  logic [AW-1:0]      ra2;
  logic [WIDTH-1:0]   rd1;
  logic [WIDTH-1:0]   rd2;
  logic               busy;

  modport master (
    output clr, we, wa, wd, wbe, re, ra1, ra2,
    input  rd1, rd2, busy
  );

  modport slave (
    input  clr, we, wa, wd, wbe, re, ra1, ra2,
    output rd1, rd2, busy
  );
endinterface

// File: rtl/reg_bank.sv
// Multi-entry register file: byte-enabled single write, two registered read latches, clear-all sweep.
// Latency: write 1 edge (0 with BYPASS into the read latches); read 1 edge; clear DEPTH edges.
// Backpressure: none; while busy, writes are dropped and read latches load zero.
module reg_bank #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         rst,
  reg_bank_if.slave   bus
);
  localparam int NB = WIDTH / 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    idx, idx_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd1_q, rd2_q;
  logic [WIDTH-1:0] be_mask;
  logic [WIDTH-1:0] wr_merge;
  logic [WIDTH-1:0] val1, val2;
  logic             busy_w;
  logic             wr_ok;

  // The sweep owns the array for its whole duration, including the edge clr is sampled on.
  assign busy_w = (state == CLEAR);
  assign wr_ok  = bus.we && !busy_w && !bus.clr &&
                  !((ZERO_REG != 0) && (bus.wa == '0));

  // Expand byte enables into a bit mask for merging.
  always_comb begin
    be_mask = '0;
    for (int i = 0; i < NB; i++) begin
      be_mask[8*i +: 8] = {8{bus.wbe[i]}};
    end
  end

  // Post-write image of the addressed entry, used for same-edge forwarding.
  assign wr_merge = (mem[bus.wa] & ~be_mask) | (bus.wd & be_mask);

  // Port 1 read value: hardwired zero, forwarded write, or stored data.
  always_comb begin
    val1 = mem[bus.ra1];
    if ((ZERO_REG != 0) && (bus.ra1 == '0)) begin
      val1 = '0;
    end else if ((BYPASS != 0) && wr_ok && (bus.wa == bus.ra1)) begin
      val1 = wr_merge;
    end
  end

  // Port 2 read value: same selection as port 1.
  always_comb begin
    val2 = mem[bus.ra2];
    if ((ZERO_REG != 0) && (bus.ra2 == '0)) begin
      val2 = '0;
    end else if ((BYPASS != 0) && wr_ok && (bus.wa == bus.ra2)) begin
      val2 = wr_merge;
    end
  end

  // Sweep FSM next-state: start on clr, walk every index once, then return to idle.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (bus.clr) begin
          state_nxt = CLEAR;
          idx_nxt   = '0;
        end
      end
      CLEAR: begin
        idx_nxt = idx + 1'b1;
        if (idx == AW'(DEPTH - 1)) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Sweep FSM state and index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Storage: sweep zeroing takes priority, otherwise apply enabled bytes of an accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (busy_w) begin
      mem[idx] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wbe[i]) begin
          mem[bus.wa][8*i +: 8] <= bus.wd[8*i +: 8];
        end
      end
    end
  end

  // Operand latches: load on re, forced to zero while the sweep runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else if (bus.re) begin
      rd1_q <= busy_w ? '0 : val1;
      rd2_q <= busy_w ? '0 : val2;
    end
  end

  assign bus.rd1  = rd1_q;
  assign bus.rd2  = rd2_q;
  assign bus.busy = busy_w;
endmodule
